// File: rtl/memory_access.sv
// Memory stage: data-cache request/ack handshake, store lane steering and load formatting.
// Optional build macro MISALIGN_TRAP_EN turns misaligned half/word accesses into error completions.
module memory_access #(
   parameter int         TIMEOUT  = 16,
   parameter logic [6:0] OP_LOAD  = 7'b0000011,
   parameter logic [6:0] OP_STORE = 7'b0100011
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [6:0]  opcode,
   input  logic [2:0]  funct3,
   input  logic [31:0] alu_out,
   input  logic [31:0] rs2_data,
   output logic        busy,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic [3:0]  mem_wstrb,
   input  logic [31:0] mem_rdata,
   input  logic        mem_ack,
   output logic [31:0] dcache_out,
   output logic        done,
   output logic        err
);
   typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

   localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [CW-1:0] TO_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

   state_t          state, state_nxt;
   logic [CW-1:0]   cnt;
   logic [2:0]      f3_q;
   logic [1:0]      lo_q;
   logic            trap_q;
   logic            is_load, is_store, is_mem, is_byte, is_half, misalign;
   logic            acked, timed_out;
   logic [3:0]      wstrb_nxt;
   logic [31:0]     wdata_nxt;
   logic [3:0][7:0] rbytes;
   logic [7:0]      ld_byte;
   logic [15:0]     ld_half;
   logic [31:0]     ld_data;

   always_comb begin
      is_load  = (opcode == OP_LOAD);
      is_store = (opcode == OP_STORE);
      is_mem   = is_load | is_store;
      // Loads alias the unsigned variants onto funct3[1:0]; stores only know SB/SH.
      is_byte  = is_store ? (funct3 == 3'b000) : (funct3[1:0] == 2'b00);
      is_half  = is_store ? (funct3 == 3'b001) : (funct3[1:0] == 2'b01);
`ifdef MISALIGN_TRAP_EN
      misalign = (is_half && alu_out[0]) || (!is_byte && !is_half && (alu_out[1:0] != 2'b00));
`else
      misalign = 1'b0;
`endif
      wstrb_nxt = 4'b0000;
      wdata_nxt = 32'h0;
      if (is_store) begin
         if (is_byte) begin
            wstrb_nxt = 4'b0001 << alu_out[1:0];
            wdata_nxt = {4{rs2_data[7:0]}};
         end else if (is_half) begin
            wstrb_nxt = 4'b0011 << {alu_out[1], 1'b0};
            wdata_nxt = {2{rs2_data[15:0]}};
         end else begin
            wstrb_nxt = 4'b1111;
            wdata_nxt = rs2_data;
         end
      end
   end

   always_comb begin
      rbytes  = mem_rdata;
      ld_byte = rbytes[lo_q];
      ld_half = lo_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
      case (f3_q)
         3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
         3'b100:  ld_data = {24'h0, ld_byte};
         3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
         3'b101:  ld_data = {16'h0, ld_half};
         default: ld_data = mem_rdata;
      endcase
   end

   // Ack on the last allowed cycle still completes normally.
   assign acked     = (state == REQ) && mem_ack;
   assign timed_out = (TIMEOUT > 0) && (state == REQ) && !mem_ack && (cnt == TO_LAST);
   assign busy      = (state != IDLE);

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start && is_mem) state_nxt = misalign ? RESP : REQ;
         REQ:     if (acked || timed_out) state_nxt = RESP;
         RESP:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt        <= '0;
         f3_q       <= 3'b000;
         lo_q       <= 2'b00;
         trap_q     <= 1'b0;
         mem_req    <= 1'b0;
         mem_we     <= 1'b0;
         mem_addr   <= 32'h0;
         mem_wdata  <= 32'h0;
         mem_wstrb  <= 4'b0000;
         dcache_out <= 32'h0;
         done       <= 1'b0;
         err        <= 1'b0;
      end else begin
         done <= 1'b0;
         err  <= 1'b0;
         case (state)
            IDLE: if (start) begin
               if (!is_mem) begin
                  done       <= 1'b1;
                  dcache_out <= 32'h0;
               end else begin
                  f3_q      <= funct3;
                  lo_q      <= alu_out[1:0];
                  trap_q    <= misalign;
                  cnt       <= '0;
                  mem_req   <= !misalign;
                  mem_we    <= is_store;
                  mem_addr  <= {alu_out[31:2], 2'b00};
                  mem_wdata <= wdata_nxt;
                  mem_wstrb <= wstrb_nxt;
               end
            end
            REQ: begin
               if (acked) begin
                  mem_req    <= 1'b0;
                  done       <= 1'b1;
                  dcache_out <= mem_we ? 32'h0 : ld_data;
               end else if (timed_out) begin
                  mem_req    <= 1'b0;
                  done       <= 1'b1;
                  err        <= 1'b1;
                  dcache_out <= 32'h0;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            RESP: begin
               // A trapped access uses RESP as a staging cycle and completes on the way out.
               if (trap_q) begin
                  done       <= 1'b1;
                  err        <= 1'b1;
                  dcache_out <= 32'h0;
                  trap_q     <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_memory_access.sv
// Scoreboard bench for memory_access: expected completions are queued at start, checked on done.
module tb_memory_access;
   localparam logic [6:0] OP_LOAD  = 7'b0000011;
   localparam logic [6:0] OP_STORE = 7'b0100011;
   localparam logic [6:0] OP_OP    = 7'b0110011;

   logic        clk, rst, start, busy, mem_req, mem_we, mem_ack, done, err;
   logic [6:0]  opcode;
   logic [2:0]  funct3;
   logic [31:0] alu_out, rs2_data, mem_addr, mem_wdata, mem_rdata, dcache_out;
   logic [3:0]  mem_wstrb;

   typedef struct {
      logic [31:0] d;
      logic        e;
   } exp_t;
   exp_t sbq[$];

   int total = 0;
   int bad   = 0;
   int ndone = 0;
   bit poke  = 0;

   memory_access #(.TIMEOUT(16)) dut (
      .clk(clk), .rst(rst), .start(start), .opcode(opcode), .funct3(funct3),
      .alu_out(alu_out), .rs2_data(rs2_data), .busy(busy), .mem_req(mem_req),
      .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
      .mem_rdata(mem_rdata), .mem_ack(mem_ack), .dcache_out(dcache_out), .done(done), .err(err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   always @(negedge clk) begin
      if (done === 1'b1) begin
         exp_t e;
         ndone++;
         chk("sb_has_entry", 32'(sbq.size() != 0), 32'd1);
         if (sbq.size() != 0) begin
            e = sbq.pop_front();
            chk("dout", dcache_out, e.d);
            chk("err", {31'h0, err}, {31'h0, e.e});
         end
      end
   end

   // One memory access: ack arrives in REQ cycle dly+1 (dly=0 means first REQ cycle).
   task automatic do_mem(input logic [6:0] opc, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] rs2, input logic [31:0] rdata, input int dly,
                         input logic [31:0] exp_out, input logic [3:0] exp_strb,
                         input logic [31:0] exp_wdata);
      int n0;
      logic [31:0] exp_addr;
      exp_addr = {addr[31:2], 2'b00};
      n0 = ndone;
      @(negedge clk);
      start = 1'b1; opcode = opc; funct3 = f3; alu_out = addr; rs2_data = rs2;
      sbq.push_back('{d: exp_out, e: 1'b0});
      @(negedge clk);
      start = 1'b0;
      chk("req_c1", {31'h0, mem_req}, 32'd1);
      chk("busy_c1", {31'h0, busy}, 32'd1);
      chk("addr", mem_addr, exp_addr);
      chk("we", {31'h0, mem_we}, {31'h0, opc == OP_STORE});
      chk("wstrb", {28'h0, mem_wstrb}, {28'h0, exp_strb});
      if (opc == OP_STORE) chk("wdata", mem_wdata, exp_wdata);
      for (int i = 0; i <= dly; i++) begin
         if (i > 0) begin
            @(negedge clk);
            chk("req_hold", {31'h0, mem_req}, 32'd1);
            chk("addr_hold", mem_addr, exp_addr);
            chk("done_early", {31'h0, done}, 32'd0);
         end
         if (i == 1 && poke) begin start = 1'b1; opcode = OP_OP; end
         else start = 1'b0;
         if (i == dly) begin mem_ack = 1'b1; mem_rdata = rdata; end
      end
      @(negedge clk);
      mem_ack = 1'b0; start = 1'b0; mem_rdata = 32'h0;
      chk("done_lat", {31'h0, done}, 32'd1);
      chk("req_drop", {31'h0, mem_req}, 32'd0);
      @(negedge clk);
      chk("done_1cyc", {31'h0, done}, 32'd0);
      chk("done_count", ndone - n0, 1);
   endtask

   initial begin
      int n, n0;
      rst = 1'b1; start = 1'b0; opcode = 7'h0; funct3 = 3'h0; alu_out = 32'h0;
      rs2_data = 32'h0; mem_rdata = 32'h0; mem_ack = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_busy", {31'h0, busy}, 32'd0);
      chk("rst_req", {31'h0, mem_req}, 32'd0);
      chk("rst_we", {31'h0, mem_we}, 32'd0);
      chk("rst_done", {31'h0, done}, 32'd0);
      chk("rst_err", {31'h0, err}, 32'd0);
      chk("rst_addr", mem_addr, 32'h0);
      chk("rst_wdata", mem_wdata, 32'h0);
      chk("rst_wstrb", {28'h0, mem_wstrb}, 32'h0);
      chk("rst_dout", dcache_out, 32'h0);
      rst = 1'b0;

      do_mem(OP_LOAD, 3'b000, 32'h1003, 32'h0, 32'h80FF1234, 0, 32'hFFFFFF80, 4'b0000, 32'h0);
      poke = 1;
      do_mem(OP_LOAD, 3'b101, 32'h2002, 32'h0, 32'hBEEF0000, 2, 32'h0000BEEF, 4'b0000, 32'h0);
      poke = 0;
      do_mem(OP_STORE, 3'b000, 32'h0011, 32'h000000A5, 32'hFFFFFFFF, 1, 32'h0, 4'b0010, 32'hA5A5A5A5);
      do_mem(OP_STORE, 3'b010, 32'h0020, 32'h12345678, 32'hFFFFFFFF, 0, 32'h0, 4'b1111, 32'h12345678);
      do_mem(OP_STORE, 3'b001, 32'h0022, 32'hCAFEBEEF, 32'h0, 0, 32'h0, 4'b1100, 32'hBEEFBEEF);
      do_mem(OP_LOAD, 3'b001, 32'h0030, 32'h0, 32'h00008001, 0, 32'hFFFF8001, 4'b0000, 32'h0);
      do_mem(OP_LOAD, 3'b100, 32'h0041, 32'h0, 32'h0000C300, 1, 32'h000000C3, 4'b0000, 32'h0);
      do_mem(OP_LOAD, 3'b010, 32'h0050, 32'h0, 32'hDEADBEEF, 0, 32'hDEADBEEF, 4'b0000, 32'h0);

      // Non-memory opcode completes in one cycle without touching the cache.
      @(negedge clk);
      start = 1'b1; opcode = OP_OP; alu_out = 32'h1234;
      sbq.push_back('{d: 32'h0, e: 1'b0});
      @(negedge clk);
      start = 1'b0;
      chk("op_done_c1", {31'h0, done}, 32'd1);
      chk("op_noreq", {31'h0, mem_req}, 32'd0);
      @(negedge clk);
      chk("op_done_1cyc", {31'h0, done}, 32'd0);

      // Stray acks in IDLE must not complete anything.
      n0 = ndone;
      mem_ack = 1'b1;
      repeat (2) @(negedge clk);
      mem_ack = 1'b0;
      @(negedge clk);
      chk("idle_ack_busy", {31'h0, busy}, 32'd0);
      chk("idle_ack_done", ndone - n0, 0);

      // Timeout on an unanswered word load.
      @(negedge clk);
      start = 1'b1; opcode = OP_LOAD; funct3 = 3'b010; alu_out = 32'h3000;
      sbq.push_back('{d: 32'h0, e: 1'b1});
      @(negedge clk);
      start = 1'b0;
      n = 0;
      while (mem_req === 1'b1 && n < 40) begin
         n++;
         @(negedge clk);
      end
      chk("to_req_cycles", n, 16);
      chk("to_done", {31'h0, done}, 32'd1);
      @(negedge clk);
      chk("to_done_1cyc", {31'h0, done}, 32'd0);

      // Reset in the middle of REQ aborts silently.
      n0 = ndone;
      @(negedge clk);
      start = 1'b1; opcode = OP_LOAD; funct3 = 3'b010; alu_out = 32'h4000;
      @(negedge clk);
      start = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_mid_req_before", {31'h0, mem_req}, 32'd1);
      rst = 1'b1;
      @(negedge clk);
      chk("rst_mid_req", {31'h0, mem_req}, 32'd0);
      chk("rst_mid_busy", {31'h0, busy}, 32'd0);
      rst = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_mid_nodone", ndone - n0, 0);

`ifdef MISALIGN_TRAP_EN
      @(negedge clk);
      start = 1'b1; opcode = OP_LOAD; funct3 = 3'b010; alu_out = 32'h1002;
      sbq.push_back('{d: 32'h0, e: 1'b1});
      @(negedge clk);
      start = 1'b0;
      chk("mis_req_c1", {31'h0, mem_req}, 32'd0);
      chk("mis_done_c1", {31'h0, done}, 32'd0);
      @(negedge clk);
      chk("mis_req_c2", {31'h0, mem_req}, 32'd0);
      chk("mis_done_c2", {31'h0, done}, 32'd1);
      @(negedge clk);
`else
      do_mem(OP_LOAD, 3'b010, 32'h1002, 32'h0, 32'h11223344, 0, 32'h11223344, 4'b0000, 32'h0);
`endif

      chk("sb_empty", sbq.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/memory_access.md
Name: memory_access

Overview:
- Memory stage of the TinyRisc-V core, between execute and writeback.
- Takes a decoded instruction from execute: opcode, funct3, ALU address, store data.
- For loads and stores, runs a request/ack transaction on the data-cache port, then formats load data with byte lane selection and sign/zero extension.
- Presents `dcache_out` and a one-cycle `done` pulse to writeback.

Parameters:
- TIMEOUT, 16: cycles to wait for `mem_ack` before aborting. 0 disables the timeout.
- OP_LOAD, 7'b0000011: load opcode.
- OP_STORE, 7'b0100011: store opcode.

Ports:
- clk  input  1  core clock
- rst  input  1  synchronous, active-high reset
- start  input  1  instruction valid from execute; sampled only in IDLE
- opcode  input  7  instruction opcode
- funct3  input  3  access size/sign
- alu_out  input  32  effective address
- rs2_data  input  32  store source data
- busy  output  1  high whenever state != IDLE
- mem_req  output  1  cache request, held until acked
- mem_we  output  1  1 = store
- mem_addr  output  32  word address: {alu_out[31:2], 2'b00}
- mem_wdata  output  32  lane-replicated store data
- mem_wstrb  output  4  byte write enables; 0 for loads
- mem_rdata  input  32  cache read word
- mem_ack  input  1  cache completes request this cycle
- dcache_out  output  32  formatted load data to writeback
- done  output  1  one-cycle completion pulse to writeback
- err  output  1  qualifies `done`: access aborted

Behaviour:
- One clock; reset is synchronous and active-high.
- Reset values: state=IDLE; `busy`, `mem_req`, `mem_we`, `done`, `err` = 0; `mem_addr`, `mem_wdata`, `mem_wstrb`, `dcache_out` = 0. Timeout counter = 0.
- States: IDLE, REQ, RESP.
- IDLE, `start`=1 with load/store opcode:
  - Latch opcode, funct3 and address low bits.
  - Drive `mem_addr`, `mem_we`, `mem_wdata` and `mem_wstrb` as registers.
  - `mem_req`=1 from the next cycle. Go to REQ.
- IDLE, `start`=1 with any other opcode: stay IDLE; `done`=1 next cycle, `dcache_out`=0, `err`=0.
- REQ: `mem_req` stays 1 and all `mem_*` outputs are stable until the cycle `mem_ack`=1.
  - On ack: `mem_req`=0 next cycle; register formatted `mem_rdata` (loads) or 0 (stores) into `dcache_out`; go to RESP.
  - Ack seen in the first REQ cycle: 1-cycle memory latency.
- RESP: `done`=1 for exactly one cycle, then IDLE.
- Latency: start at cycle 0, ack at cycle k≥1 → `done` at cycle k+1. Non-memory op → `done` at cycle 1.
- Load formatting, `b` = addr[1:0]:
  - funct3=000: LB, sign-extend byte b.
  - funct3=100: LBU, zero-extend byte b.
  - funct3=001: LH, sign-extend halfword addr[1].
  - funct3=101: LHU, zero-extend halfword addr[1].
  - funct3=010 and all other values: full word.
- Store strobes and data:
  - funct3=000 (SB): `mem_wstrb` = 4'b0001 << b; `mem_wdata` = byte replicated ×4.
  - funct3=001 (SH): `mem_wstrb` = 4'b0011 << {addr[1],1'b0}; `mem_wdata` = halfword replicated ×2.
  - otherwise (SW): `mem_wstrb` = 4'b1111; `mem_wdata` = `rs2_data`.
- Timeout (TIMEOUT>0):
  - Counter clears on entering REQ and increments each REQ cycle without ack.
  - When it reaches TIMEOUT: drop `mem_req`, go to RESP with `err`=1 and `dcache_out`=0. `err` is valid only while `done`=1.
  - An ack in the same cycle as the timeout wins; the access is not aborted.
- `start` while `busy` is ignored; execute must stall on `busy`.
- `mem_ack` outside REQ is ignored.
- `rst` mid-transaction: IDLE at the next edge, `mem_req`=0, no `done`.

Optional Feature:
- Macro: MISALIGN_TRAP_EN.
- Defined:
  - A halfword access with addr[0]=1, or a word access with addr[1:0]≠0, issues no cache request.
  - The block goes IDLE → RESP directly: `done`=1 at cycle 2, `err`=1, `dcache_out`=0.
- Undefined: misaligned low address bits are silently truncated as specified above, with no trap.

Test Plan:
- LB, addr=0x1003, `mem_rdata`=0x80FF1234, ack in first REQ cycle → `mem_addr`=0x1000, `done` at cycle 2, `dcache_out`=0xFFFFFF80, `err`=0.
- LHU, addr=0x2002, `mem_rdata`=0xBEEF0000, ack after 3 REQ cycles → `mem_req` held stable 3 cycles, `dcache_out`=0x0000BEEF, `done` one cycle only.
- SB, addr=0x11, `rs2_data`=0x000000A5 → `mem_we`=1, `mem_wstrb`=0010, `mem_wdata`=0xA5A5A5A5; SW → `mem_wstrb`=1111; `dcache_out`=0 on `done`.
- OP_OP (7'b0110011) with start → `mem_req` never asserted, `done`=1 at cycle 1, `dcache_out`=0; a second `start` while `busy` has no effect.
- LW with no ack, TIMEOUT=16 → `mem_req` high 16 cycles then drops, `done`=1 with `err`=1; `rst` asserted mid-REQ → `mem_req`=0 next cycle, no `done`.
- With MISALIGN_TRAP_EN, LW at 0x1002 → no `mem_req`, `done` and `err`=1 at cycle 2. Without the macro → `mem_addr`=0x1000, normal completion.
